// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// RISC-V load/store funct3 codes and the access-size decoder.
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD       = 3'd1,
      WR_SETUP = 3'd2,
      WR_PULSE = 3'd3,
      RESP     = 3'd4
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Number of bytes touched by an access; 0 marks an illegal funct3.
   function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
      logic [2:0] n;
      case (funct3)
         F3_B, F3_BU: n = 3'd1;
         F3_H, F3_HU: n = 3'd2;
         F3_W:        n = 3'd4;
         default:     n = 3'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational load-data extension: assembled little-endian bytes plus funct3
// in, sign- or zero-extended register value out.
module lsu_extend
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] raw,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   always_comb begin
      data = '0;
      case (funct3)
         F3_B:    data = {{(XLEN-8){raw[7]}}, raw[7:0]};
         F3_H:    data = {{(XLEN-16){raw[15]}}, raw[15:0]};
         F3_W:    data = raw;
         F3_BU:   data = {{(XLEN-8){1'b0}}, raw[7:0]};
         F3_HU:   data = {{(XLEN-16){1'b0}}, raw[15:0]};
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: serialises one RISC-V load/store into byte accesses on a
// byte-wide ram. Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int CELL_SIZE = 8,
   parameter int MEM_SIZE  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [2:0]           req_funct3,
   input  logic [XLEN-1:0]      req_addr,
   input  logic [XLEN-1:0]      req_wdata,
   output logic                 resp_valid,
   output logic [XLEN-1:0]      resp_rdata,
   output logic                 resp_err,
   output logic [MEM_SIZE-1:0]  mem_addr,
   output logic                 mem_write_en,
   inout  wire  [CELL_SIZE-1:0] mem_data
);

   lsu_state_t           state, state_d;
   logic [MEM_SIZE-1:0]  addr_q, addr_d;
   logic [1:0]           k_q, k_d;
   logic [2:0]           n_q, n_d;
   logic [2:0]           f3_q, f3_d;
   logic                 err_q, err_d;
   logic [XLEN-1:0]      wdata_q, wdata_d;
   logic [XLEN-1:0]      raw_q, raw_d;
   logic [CELL_SIZE-1:0] byte_q, byte_d;
   logic [XLEN-1:0]      ext_data;

   logic [2:0] req_n;
   logic       out_of_range;
   logic       misaligned;
   logic       req_bad;
   logic       last_byte;

   assign req_n = access_bytes(req_funct3);

   // Extra top bit keeps addr+N from wrapping back into the valid range.
   assign out_of_range = ({1'b0, req_addr} + (XLEN+1)'(req_n)) > (XLEN+1)'(MEM_SIZE);

`ifdef LSU_MISALIGN_TRAP_EN
   assign misaligned = ((req_n == 3'd2) && req_addr[0]) ||
                       ((req_n == 3'd4) && (req_addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   assign req_bad   = (req_n == 3'd0) || out_of_range || (req_we && req_funct3[2]) || misaligned;
   assign last_byte = ({1'b0, k_q} == (n_q - 3'd1));

   always_comb begin
      // NOTE: every signal gets its hold value first, so no path through the
      // case below can leave one unassigned and infer a latch.
      state_d = state;
      addr_d  = addr_q;
      k_d     = k_q;
      n_d     = n_q;
      f3_d    = f3_q;
      err_d   = err_q;
      wdata_d = wdata_q;
      raw_d   = raw_q;
      byte_d  = byte_q;
      case (state)
         IDLE: begin
            if (req_valid) begin
               n_d   = req_n;
               f3_d  = req_funct3;
               k_d   = '0;
               // Clearing raw makes stores and errors read back as zero.
               raw_d = '0;
               if (req_bad) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  err_d  = 1'b0;
                  addr_d = req_addr[MEM_SIZE-1:0];
                  if (req_we) begin
                     wdata_d = req_wdata;
                     byte_d  = req_wdata[CELL_SIZE-1:0];
                     state_d = WR_SETUP;
                  end else begin
                     state_d = RD;
                  end
               end
            end
         end
         RD: begin
            raw_d[int'(k_q)*CELL_SIZE +: CELL_SIZE] = mem_data;
            if (last_byte) begin
               state_d = RESP;
            end else begin
               k_d    = k_q + 2'd1;
               addr_d = addr_q + MEM_SIZE'(1);
            end
         end
         WR_SETUP: state_d = WR_PULSE;
         WR_PULSE: begin
            if (last_byte) begin
               state_d = RESP;
            end else begin
               k_d     = k_q + 2'd1;
               addr_d  = addr_q + MEM_SIZE'(1);
               byte_d  = wdata_q[int'(k_d)*CELL_SIZE +: CELL_SIZE];
               state_d = WR_SETUP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         k_q     <= '0;
         n_q     <= '0;
         f3_q    <= '0;
         err_q   <= 1'b0;
         wdata_q <= '0;
         raw_q   <= '0;
         byte_q  <= '0;
      end else begin
         // NOTE: non-blocking updates so every register samples the values
         // from before this edge, independent of statement order.
         state   <= state_d;
         addr_q  <= addr_d;
         k_q     <= k_d;
         n_q     <= n_d;
         f3_q    <= f3_d;
         err_q   <= err_d;
         wdata_q <= wdata_d;
         raw_q   <= raw_d;
         byte_q  <= byte_d;
      end
   end

   lsu_extend #(.XLEN(XLEN)) u_extend (
      .raw    (raw_q),
      .funct3 (f3_q),
      .data   (ext_data)
   );

   // Write strobe is a pure state decode, so an async reset drops it at once.
   assign req_ready    = (state == IDLE);
   assign resp_valid   = (state == RESP);
   assign resp_err     = resp_valid && err_q;
   assign resp_rdata   = resp_valid ? ext_data : '0;
   assign mem_addr     = addr_q;
   assign mem_write_en = (state == WR_PULSE);
   assign mem_data     = mem_write_en ? byte_q : {CELL_SIZE{1'bz}};

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte ram model on the tristate bus, queue-based
// reference model of request results, directed plan cases and random traffic.
module tb_load_store_unit;
   import lsu_pkg::*;

   localparam int MEM_SIZE = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   wire         req_ready, resp_valid, resp_err, mem_write_en;
   wire  [31:0] resp_rdata;
   wire  [7:0]  mem_addr;
   wire  [7:0]  mem_data;

   always #5 clk = ~clk;

   load_store_unit #(.XLEN(32), .CELL_SIZE(8), .MEM_SIZE(MEM_SIZE)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_addr     (mem_addr),
      .mem_write_en (mem_write_en),
      .mem_data     (mem_data)
   );

   // Ram: combinational read driven only during loads; a released bus floats high.
   logic [7:0] ram_mem   [0:MEM_SIZE-1];
   logic [7:0] model_mem [0:MEM_SIZE-1];
   logic       load_active = 1'b0;
   wire  [7:0] ram_rd = (mem_addr < 8'(MEM_SIZE)) ? ram_mem[mem_addr[2:0]] : 8'h00;
   assign mem_data = load_active ? ram_rd : 8'bz;
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (mem_data[g]);
   end

   int n_err = 0;
   int n_checks = 0;
   int cyc = 0;
   int pulses = 0;
   logic [7:0] wr_addr_lat, wr_data_lat;

   typedef struct {
      int          acc;
      int          lat;
      logic        err;
      logic [31:0] rdata;
      int          npulse;
      int          pbase;
   } exp_t;
   exp_t exp_q[$];

   int          last_lat;
   logic        last_err;
   logic [31:0] last_rdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(posedge mem_write_en) begin
      pulses++;
      #1;
      if (mem_write_en === 1'b1) begin
         wr_addr_lat = mem_addr;
         wr_data_lat = mem_data;
         if (mem_addr < 8'(MEM_SIZE)) ram_mem[mem_addr[2:0]] = mem_data;
         else check("wr_addr_range", {24'h0, mem_addr}, 32'h0);
      end
   end

   always @(negedge rst) exp_q.delete();

   // Per-cycle compare against the queued model results.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (resp_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_resp", 32'h1, 32'h0);
            end else begin
               e = exp_q.pop_front();
               check("resp_latency", cyc - e.acc, e.lat);
               check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
               check("resp_rdata", resp_rdata, e.rdata);
               check("write_pulses", pulses - e.pbase, e.npulse);
               last_lat   = cyc - e.acc;
               last_err   = resp_err;
               last_rdata = resp_rdata;
            end
         end else if (exp_q.size() != 0 && cyc > exp_q[0].acc + exp_q[0].lat) begin
            check("resp_missing", cyc, exp_q[0].acc + exp_q[0].lat);
            void'(exp_q.pop_front());
         end
         if (!mem_write_en && !load_active) check("bus_release", {24'h0, mem_data}, 32'hFF);
         if (mem_write_en) begin
            check("wr_addr_stable", {24'h0, mem_addr}, {24'h0, wr_addr_lat});
            check("wr_data_stable", {24'h0, mem_data}, {24'h0, wr_data_lat});
         end
      end
   end

   // Present a request, wait for the handshake, queue the model's verdict.
   task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int acc);
      int          n;
      logic        err;
      logic [31:0] v;
      logic [31:0] rd;
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      acc = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (req_ready) break;
      end
      if (!req_ready) begin
         check("accept_timeout", 32'h0, 32'h1);
         return;
      end
      n   = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 0;
      err = (n == 0) || (({1'b0, addr} + 33'(n)) > 33'(MEM_SIZE)) || (we && f3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
      if ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00)) err = 1'b1;
`endif
      rd = 32'h0;
      if (!err && !we) begin
         v = 32'h0;
         for (int j = 0; j < n; j++) v = v | (32'(model_mem[int'(addr) + j]) << (8 * j));
         case (f3)
            3'd0:    rd = {{24{v[7]}}, v[7:0]};
            3'd1:    rd = {{16{v[15]}}, v[15:0]};
            3'd4:    rd = {24'h0, v[7:0]};
            3'd5:    rd = {16'h0, v[15:0]};
            default: rd = v;
         endcase
      end
      if (!err && we)
         for (int j = 0; j < n; j++) model_mem[int'(addr) + j] = wdata[8*j +: 8];
      exp_q.push_back('{acc: cyc, lat: (err ? 1 : (we ? 2*n + 1 : n + 1)), err: err, rdata: rd,
                        npulse: ((we && !err) ? n : 0), pbase: pulses});
      acc = cyc;
      @(posedge clk); #1;
      if (!we && !err) load_active = 1'b1;
   endtask

   task automatic finish_req();
      req_valid = 1'b0;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         check("resp_timeout", exp_q.size(), 32'h0);
         exp_q.delete();
      end
      @(posedge clk); #1;
      load_active = 1'b0;
   endtask

   task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
      int a;
      send(we, f3, addr, wdata, a);
      finish_req();
   endtask

   task automatic check_mem(input string name);
      int bad = 0;
      for (int i = 0; i < MEM_SIZE; i++) if (ram_mem[i] !== model_mem[i]) bad++;
      check(name, bad, 32'h0);
   endtask

   initial begin
      int          c1, c2, p0;
      logic [7:0]  snap [0:MEM_SIZE-1];
      for (int i = 0; i < MEM_SIZE; i++) begin
         ram_mem[i]   = 8'h10 + 8'(i);
         model_mem[i] = 8'h10 + 8'(i);
      end

      #2;
      check("rst_ready", {31'h0, req_ready}, 32'h1);
      check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      check("rst_resp_err", {31'h0, resp_err}, 32'h0);
      check("rst_rdata", resp_rdata, 32'h0);
      check("rst_mem_addr", {24'h0, mem_addr}, 32'h0);
      check("rst_write_en", {31'h0, mem_write_en}, 32'h0);
      check("rst_bus", {24'h0, mem_data}, 32'hFF);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      // Word store then the plan's loads back.
      p0 = pulses;
      op(1'b1, F3_W, 32'd0, 32'hDEADBEEF);
      check("sw_lat", last_lat, 32'd9);
      check("sw_pulses", pulses - p0, 32'd4);
      check("sw_cells", {ram_mem[3], ram_mem[2], ram_mem[1], ram_mem[0]}, 32'hDEADBEEF);
      op(1'b0, F3_B, 32'd3, 32'h0);
      check("lb3", last_rdata, 32'hFFFFFFDE);
      check("lb3_lat", last_lat, 32'd2);
      op(1'b0, F3_BU, 32'd3, 32'h0);
      check("lbu3", last_rdata, 32'h000000DE);
      op(1'b0, F3_H, 32'd2, 32'h0);
      check("lh2", last_rdata, 32'hFFFFDEAD);
      check("lh2_lat", last_lat, 32'd3);
      op(1'b0, F3_W, 32'd0, 32'h0);
      check("lw0", last_rdata, 32'hDEADBEEF);
      check("lw0_lat", last_lat, 32'd5);

      // Range and encoding errors.
      p0 = pulses;
      op(1'b0, F3_W, 32'd5, 32'h0);
      check("lw5_err", {31'h0, last_err}, 32'h1);
      check("lw5_lat", last_lat, 32'd1);
      check("lw5_rdata", last_rdata, 32'h0);
      check("lw5_pulses", pulses - p0, 32'd0);
      op(1'b0, F3_B, 32'd7, 32'h0);
      check("lb7_err", {31'h0, last_err}, 32'h0);
      check("lb7", last_rdata, 32'h00000017);
      op(1'b1, 3'b100, 32'd0, 32'h55);
      check("sbu_err", {31'h0, last_err}, 32'h1);
      op(1'b0, F3_W, 32'hFFFFFFFE, 32'h0);
      check("lw_wrap_err", {31'h0, last_err}, 32'h1);

      // Misaligned halfword.
      op(1'b0, F3_H, 32'd1, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("lh1_err", {31'h0, last_err}, 32'h1);
      check("lh1", last_rdata, 32'h0);
`else
      check("lh1_err", {31'h0, last_err}, 32'h0);
      check("lh1", last_rdata, 32'hFFFFADBE);
`endif

      // Reset during the second write pulse of a word store at 4.
      for (int i = 0; i < MEM_SIZE; i++) snap[i] = model_mem[i];
      p0 = pulses;
      send(1'b1, F3_W, 32'd4, 32'h12345678, c1);
      req_valid = 1'b0;
      for (int i = 0; i < 20 && pulses - p0 < 2; i++) @(negedge clk);
      check("abort_reach", pulses - p0, 32'd2);
      rst = 1'b0;
      #1;
      check("abort_we_drop", {31'h0, mem_write_en}, 32'h0);
      check("abort_no_resp", {31'h0, resp_valid}, 32'h0);
      for (int i = 0; i < MEM_SIZE; i++) model_mem[i] = snap[i];
      model_mem[4] = 8'h78;
      model_mem[5] = 8'h56;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("abort_ready", {31'h0, req_ready}, 32'h1);
      check("abort_cell6", {24'h0, ram_mem[6]}, {24'h0, snap[6]});
      check_mem("abort_mem");
      repeat (4) @(negedge clk);
      @(posedge clk); #1;

      // Valid held across a store: next accept is the cycle after its response.
      send(1'b1, F3_W, 32'd0, 32'hA1B2C3D4, c1);
      send(1'b0, F3_W, 32'd0, 32'h0, c2);
      finish_req();
      check("hold_accept", c2 - c1, 32'd10);
      check("hold_load", last_rdata, 32'hA1B2C3D4);

      // Random traffic.
      for (int t = 0; t < 250; t++) begin
         logic [31:0] a;
         int r;
         r = $urandom_range(0, 10);
         a = (r >= 9) ? 32'hFFFFFFFF - 32'($urandom_range(0, 3)) : 32'(r);
         op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
      check_mem("final_mem");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU execute stage and the byte-wide ram. Directly upstream of the ram: drives its addr, write_en and bidirectional data bus.
- Accepts one RISC-V load/store request at a time: LB/LH/LW/LBU/LHU/SB/SH/SW.
- Serialises each request into little-endian byte accesses.
- Returns sign/zero-extended load data or a store completion, plus an error flag.

Parameters:
- XLEN, 32, width of request address and data.
- CELL_SIZE, 8, ram cell width. Only 8 is supported.
- MEM_SIZE, 8, ram address width and ram depth. Valid byte addresses are 0..MEM_SIZE-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE. Handshake fires when valid && ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data; the low 1/2/4 bytes are used.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid.
- mem_addr  out  MEM_SIZE  to ram addr.
- mem_write_en  out  1  to ram write_en.
- mem_data  inout  CELL_SIZE  to ram data. Driven only while mem_write_en==1, else high-Z.

Behaviour:
- Reset (rst==0, async):
  - State IDLE.
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_addr=0, mem_write_en=0, mem_data released.
  - Reset mid-operation aborts immediately: mem_write_en drops in the same delta, and remaining bytes are not written.
- States: IDLE, RD, WR_SETUP, WR_PULSE, RESP.
- Access size N: 1 for B/BU, 2 for H/HU, 4 for W.
- Error check at accept (error goes straight to RESP with resp_err=1 and no ram access). Errors are:
  - req_addr+N > MEM_SIZE (address arithmetic done in XLEN+1 bits, no wrap);
  - funct3 011/110/111;
  - a store with funct3[2]=1.
- IDLE + handshake, load:
  - mem_addr<=addr[MEM_SIZE-1:0], k<=0, go to RD.
  - In each RD cycle, mem_data (combinational ram output) is captured into byte k at the rising edge; mem_addr increments and k increments.
  - After byte N-1, go to RESP.
  - Load latency: N+1 cycles from accept to resp_valid.
- IDLE + handshake, store:
  - Latch wdata, go to WR_SETUP.
  - WR_SETUP: mem_addr = base+k and the byte register = wdata[8k+7:8k] are stable; mem_write_en=0; bus released.
  - WR_PULSE: mem_write_en=1 and the bus is driven with the byte register. The ram writes on the 0->1 edge.
  - Next cycle: back to WR_SETUP for k+1, so write_en is guaranteed low at least 1 cycle between bytes. After byte N-1, go to RESP.
  - Addr and data never change while mem_write_en==1.
  - Store latency: 2N+1 cycles from accept to resp_valid.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Extension:
  - B/H are sign-extended from bit 7/15.
  - BU/HU are zero-extended.
  - W is passed through.
- req_valid while not IDLE is ignored (ready=0). Requests are never queued.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: H/HU/SH with addr[0]!=0, and W/SW with addr[1:0]!=0, give resp_err=1 with no ram access.
- Undefined: misaligned accesses are legal and serialised byte-wise like any other.

Decomposition:
- lsu_pkg holds:
  - lsu_state_t enum;
  - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - function access_bytes(funct3) returning N (0 for illegal).
- One natural sub-module: lsu_extend, combinational: raw 32-bit byte assembly + funct3 -> extended resp_rdata.

Test Plan:
- SW addr=0 wdata=32'hDEADBEEF: exactly 4 mem_write_en pulses, cells 0..3 = EF,BE,AD,DE; resp_valid 9 cycles after accept, err=0.
- Then LB addr=3 -> resp_rdata=32'hFFFFFFDE; LBU addr=3 -> 32'h000000DE; LH addr=2 -> 32'hFFFFDEAD; LW addr=0 -> 32'hDEADBEEF. Load latency N+1.
- LW addr=5 with MEM_SIZE=8 -> resp_err=1 after 1 cycle, zero write_en pulses, rdata=0. LB addr=7 -> ok. SB funct3=100 -> err.
- Assert rst=0 during the 2nd WR_PULSE of SW addr=4 -> mem_write_en=0 immediately, cell 6 unchanged, req_ready=1 after release, no resp_valid.
- req_valid held through a store -> second request accepted only on the cycle after resp_valid. mem_data is Z whenever mem_write_en=0.
- LH addr=1:
  - with LSU_MISALIGN_TRAP_EN -> err=1 and no access;
  - without it -> data assembled from cells 1,2.
